// File: rtl/catcore_pkg.sv
// Shared definitions for the catcore command dispatcher: opcodes, LED command codes,
// FSM state encoding, response strings and the frame delimiter position.
package catcore_pkg;

    localparam logic [7:0] OP_STATUS = 8'h40;  // '@'
    localparam logic [7:0] OP_LED    = 8'h41;  // 'A'
    localparam logic [7:0] OP_KEY    = 8'h42;  // 'B'
    localparam logic [7:0] OP_RUN    = 8'h43;  // 'C'
    localparam logic [7:0] OP_KEYRD  = 8'h61;  // 'a'

    localparam logic [7:0] LED_ALL_ONES = 8'h60;  // '`'
    localparam logic [7:0] LED_CLR_BASE = 8'h41;  // 'A'
    localparam logic [7:0] LED_SET_BASE = 8'h61;  // 'a'

    localparam int RESP_W = 128;

    localparam logic [RESP_W-1:0] RESP_LED_SET   = {72'h0, "led set"};
    localparam logic [RESP_W-1:0] RESP_KEY_OK    = {80'h0, "key ok"};
    localparam logic [RESP_W-1:0] RESP_INVALID   = "invalid instruct";
    localparam logic [RESP_W-1:0] RESP_AES_TMOUT = {40'h0, "aes timeout"};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_WAIT_AES = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    function automatic int delim_idx(input int frame_bytes);
        return frame_bytes - 1;
    endfunction

endpackage

// File: rtl/catcore_led_ctrl.sv
// Active-low LED register: per-bit clear ('A'..) / set ('a'..) and all-ones ('`') updates.
module catcore_led_ctrl
    import catcore_pkg::*;
#(
    parameter int LED_W = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             cmd_stb_i,
    input  logic [7:0]       b1_i,
    output logic [LED_W-1:0] led_reg_o
);

    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;
    logic [7:0]       clr_idx_s;
    logic [7:0]       set_idx_s;
    logic             clr_hit_s;
    logic             set_hit_s;

    // Range checks keep codes past LED_W-1 from touching any bit.
    assign clr_idx_s = b1_i - LED_CLR_BASE;
    assign set_idx_s = b1_i - LED_SET_BASE;
    assign clr_hit_s = (b1_i >= LED_CLR_BASE) && (clr_idx_s < 8'(LED_W));
    assign set_hit_s = (b1_i >= LED_SET_BASE) && (set_idx_s < 8'(LED_W));

    // Next LED pattern from the current command byte.
    always_comb begin
        led_d = led_q;
        if (cmd_stb_i) begin
            if (b1_i == LED_ALL_ONES) begin
                led_d = {LED_W{1'b1}};
            end else if (clr_hit_s) begin
                for (int i = 0; i < LED_W; i++) begin
                    if (clr_idx_s == 8'(i)) begin
                        led_d[i] = 1'b0;
                    end else begin
                        led_d[i] = led_q[i];
                    end
                end
            end else if (set_hit_s) begin
                for (int i = 0; i < LED_W; i++) begin
                    if (set_idx_s == 8'(i)) begin
                        led_d[i] = 1'b1;
                    end else begin
                        led_d[i] = led_q[i];
                    end
                end
            end else begin
                led_d = led_q;
            end
        end else begin
            led_d = led_q;
        end
    end

    // LED register, all LEDs off (ones) out of reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            led_q <= {LED_W{1'b1}};
        end else begin
            led_q <= led_d;
        end
    end

    assign led_reg_o = led_q;

endmodule

// File: rtl/catcore_cmd_dispatch.sv
// UART command dispatcher: pops one frame, checks its delimiter, runs the opcode and returns one
// response frame. Define CATCORE_DEVMODE_EN to enable opcode 'a' (AES key readback).
module catcore_cmd_dispatch
    import catcore_pkg::*;
#(
    parameter int FRAME_BYTES = 18,
    parameter int LED_W       = 8,
    parameter int AES_TIMEOUT = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic [FRAME_BYTES*8-1:0] frame_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [FRAME_BYTES*8-1:0] tx_data,
    output logic [LED_W-1:0]         led_reg,
    output logic [127:0]             aes_key,
    output logic [127:0]             aes_pt,
    output logic                     aes_start,
    input  logic                     aes_done,
    input  logic [127:0]             aes_result,
    output logic                     cmd_err,
    output logic [CNT_W-1:0]         cmd_count
);

    localparam int FW    = FRAME_BYTES * 8;
    localparam int DELIM = delim_idx(FRAME_BYTES);
    localparam int TO_W  = $clog2(AES_TIMEOUT + 1);

    function automatic logic [FW-1:0] ext128(input logic [127:0] v);
        return {{(FW-128){1'b0}}, v};
    endfunction

    state_e           state_q, state_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [FW-1:0]    tx_data_q, tx_data_d;
    logic             frame_ready_q, frame_ready_d;
    logic             tx_valid_q, tx_valid_d;
    logic             aes_start_q, aes_start_d;
    logic             cmd_err_q, cmd_err_d;
    logic [127:0]     aes_key_q, aes_key_d;
    logic [127:0]     aes_pt_q, aes_pt_d;
    logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic             led_stb_s;
    logic [7:0]       opcode_s;
    logic [7:0]       b1_s;
    logic [7:0]       delim_s;
    logic [127:0]     payload_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [FW-1:0]    status_s;

    assign opcode_s  = frame_q[7:0];
    assign b1_s      = frame_q[15:8];
    assign delim_s   = frame_q[8*DELIM +: 8];
    assign payload_s = frame_q[8 +: 128];
    assign cnt_inc_s = cmd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Status reports the count including the status command itself.
    always_comb begin
        status_s = {FW{1'b0}};
        status_s[LED_W-1:0]     = led_reg;
        status_s[LED_W +: CNT_W] = cnt_inc_s;
    end

    catcore_led_ctrl #(
        .LED_W (LED_W)
    ) u_led_ctrl (
        .clk       (clk),
        .nreset    (nreset),
        .cmd_stb_i (led_stb_s),
        .b1_i      (b1_s),
        .led_reg_o (led_reg)
    );

    // Command FSM, datapath updates and response selection.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        tx_data_d   = tx_data_q;
        aes_key_d   = aes_key_q;
        aes_pt_d    = aes_pt_q;
        cmd_count_d = cmd_count_q;
        to_cnt_d    = to_cnt_q;
        aes_start_d = 1'b0;
        cmd_err_d   = 1'b0;
        led_stb_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    frame_d = frame_data;
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (delim_s != opcode_s) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cmd_count_d = cnt_inc_s;
                    state_d     = ST_RESP;
                    case (opcode_s)
                        OP_LED: begin
                            led_stb_s = 1'b1;
                            tx_data_d = ext128(RESP_LED_SET);
                        end
                        OP_KEY: begin
                            aes_key_d = payload_s;
                            tx_data_d = ext128(RESP_KEY_OK);
                        end
                        OP_RUN: begin
                            aes_pt_d    = payload_s;
                            aes_start_d = 1'b1;
                            to_cnt_d    = {TO_W{1'b0}};
                            state_d     = ST_WAIT_AES;
                        end
                        OP_STATUS: begin
                            tx_data_d = status_s;
                        end
`ifdef CATCORE_DEVMODE_EN
                        OP_KEYRD: begin
                            tx_data_d = ext128(aes_key_q);
                        end
`endif
                        default: begin
                            cmd_err_d = 1'b1;
                            tx_data_d = ext128(RESP_INVALID);
                        end
                    endcase
                end
            end
            ST_WAIT_AES: begin
                // A done on the final timeout cycle still wins.
                if (aes_done) begin
                    tx_data_d = ext128(aes_result);
                    state_d   = ST_RESP;
                end else if (to_cnt_q == TO_W'(AES_TIMEOUT - 1)) begin
                    cmd_err_d = 1'b1;
                    tx_data_d = ext128(RESP_AES_TMOUT);
                    state_d   = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        frame_ready_d = (state_d == ST_LATCH);
        tx_valid_d    = (state_d == ST_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            frame_q       <= {FW{1'b0}};
            tx_data_q     <= {FW{1'b0}};
            frame_ready_q <= 1'b0;
            tx_valid_q    <= 1'b0;
            aes_start_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            aes_key_q     <= 128'h0;
            aes_pt_q      <= 128'h0;
            cmd_count_q   <= {CNT_W{1'b0}};
            to_cnt_q      <= {TO_W{1'b0}};
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            tx_data_q     <= tx_data_d;
            frame_ready_q <= frame_ready_d;
            tx_valid_q    <= tx_valid_d;
            aes_start_q   <= aes_start_d;
            cmd_err_q     <= cmd_err_d;
            aes_key_q     <= aes_key_d;
            aes_pt_q      <= aes_pt_d;
            cmd_count_q   <= cmd_count_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign aes_key     = aes_key_q;
    assign aes_pt      = aes_pt_q;
    assign aes_start   = aes_start_q;
    assign cmd_err     = cmd_err_q;
    assign cmd_count   = cmd_count_q;

endmodule
